// File: rtl/jk_edge_monitor.sv
// jk_edge_monitor
//   Passive observer for a JK flip-flop that lives in the same clock domain.
//   It reports q edges, counts them, measures high-period lengths, checks
//   that each q value matches the JK next-state equation, and flags a toggle
//   that was commanded but never happened.
//
//   Ports
//     clk         rising-edge clock
//     rst         asynchronous reset, active low
//     q, j, k     observed flip-flop output and its J/K inputs
//     chk_en      0 while the observed flip-flop is held in its own reset
//     clr         synchronous clear of counters and sticky flags
//     rise, fall  single-cycle pulses, one cycle after the q edge is sampled
//     toggle_cnt  saturating count of q edges
//     hi_len      length of the last completed high period,
//                 hi_len_vld pulses when it updates
//     err         sticky next-state mismatch, err_cnt saturating count of them
//     stuck       sticky: j=k=1 held STUCK_LIM cycles with q unchanged
//     dbg_state   current tracking state (0 UNKNOWN, 1 LOW, 2 HIGH)
//
//   Handshake: none; every input is sampled on every rising edge and every
//   output is a register that is valid for the whole following cycle.
module jk_edge_monitor #(
   parameter int CNT_W     = 8,
   parameter int STUCK_LIM = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             q,
   input  logic             j,
   input  logic             k,
   input  logic             chk_en,
   input  logic             clr,
   output logic             rise,
   output logic             fall,
   output logic [CNT_W-1:0] toggle_cnt,
   output logic [CNT_W-1:0] hi_len,
   output logic             hi_len_vld,
   output logic             err,
   output logic [3:0]       err_cnt,
   output logic             stuck,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      ST_UNKNOWN = 2'd0,
      ST_LOW     = 2'd1,
      ST_HIGH    = 2'd2
   } state_t;

   localparam int               SC_W        = $clog2(STUCK_LIM + 1);
   localparam logic [SC_W-1:0]  STUCK_LIM_C = SC_W'(STUCK_LIM);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   state_t           state_q, state_d;
   logic             q_smp_q, j_smp_q, k_smp_q, en_smp_q;
   logic             rise_q, rise_d, fall_q, fall_d, vld_q, vld_d;
   logic [CNT_W-1:0] tog_q, tog_d, hi_len_q, hi_len_d, hi_cnt_q, hi_cnt_d;
   // hi_full marks a high period whose start was seen; a period entered from
   // UNKNOWN has no known start and must not be reported.
   logic             hi_full_q, hi_full_d;
   logic             err_q, err_d, stuck_q, stuck_d;
   logic [3:0]       err_cnt_q, err_cnt_d;
   logic [SC_W-1:0]  stuck_cnt_q, stuck_cnt_d;
   logic             edge_seen;
   logic             q_exp;

   // JK next-state from last cycle's sampled inputs and output.
   always_comb begin
      q_exp = q_smp_q;
      case ({j_smp_q, k_smp_q})
         2'b10:   q_exp = 1'b1;
         2'b01:   q_exp = 1'b0;
         2'b11:   q_exp = ~q_smp_q;
         default: q_exp = q_smp_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      rise_d      = 1'b0;
      fall_d      = 1'b0;
      vld_d       = 1'b0;
      tog_d       = tog_q;
      hi_len_d    = hi_len_q;
      hi_cnt_d    = hi_cnt_q;
      hi_full_d   = hi_full_q;
      err_d       = err_q;
      err_cnt_d   = err_cnt_q;
      stuck_d     = stuck_q;
      stuck_cnt_d = stuck_cnt_q;
      edge_seen   = 1'b0;

      case (state_q)
         ST_UNKNOWN: begin
            // First sample after reset only establishes the level.
            state_d   = q ? ST_HIGH : ST_LOW;
            hi_cnt_d  = '0;
            hi_full_d = 1'b0;
         end
         ST_LOW: begin
            if (q) begin
               state_d   = ST_HIGH;
               rise_d    = 1'b1;
               edge_seen = 1'b1;
               hi_cnt_d  = {{(CNT_W-1){1'b0}}, 1'b1};
               hi_full_d = 1'b1;
            end
         end
         ST_HIGH: begin
            if (!q) begin
               state_d   = ST_LOW;
               fall_d    = 1'b1;
               edge_seen = 1'b1;
               if (hi_full_q) begin
                  hi_len_d = hi_cnt_q;
                  vld_d    = 1'b1;
               end
            end else if (hi_full_q && hi_cnt_q != CNT_MAX) begin
               hi_cnt_d = hi_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_UNKNOWN;
      endcase

      if (edge_seen && tog_q != CNT_MAX) tog_d = tog_q + 1'b1;

      if (chk_en && en_smp_q && state_q != ST_UNKNOWN && q != q_exp) begin
         err_d = 1'b1;
         if (err_cnt_q != 4'hF) err_cnt_d = err_cnt_q + 1'b1;
      end

      if (j_smp_q && k_smp_q && chk_en && q == q_smp_q) begin
         if (stuck_cnt_q != STUCK_LIM_C) stuck_cnt_d = stuck_cnt_q + 1'b1;
         if (stuck_cnt_d == STUCK_LIM_C) stuck_d = 1'b1;
      end else begin
         stuck_cnt_d = '0;
      end

      // Clear wins over any same-cycle update; state, samples and edge
      // pulses are untouched so an edge on this cycle is still reported.
      if (clr) begin
         tog_d       = '0;
         hi_len_d    = '0;
         err_d       = 1'b0;
         err_cnt_d   = '0;
         stuck_d     = 1'b0;
         stuck_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_UNKNOWN;
         q_smp_q     <= 1'b0;
         j_smp_q     <= 1'b0;
         k_smp_q     <= 1'b0;
         en_smp_q    <= 1'b0;
         rise_q      <= 1'b0;
         fall_q      <= 1'b0;
         vld_q       <= 1'b0;
         tog_q       <= '0;
         hi_len_q    <= '0;
         hi_cnt_q    <= '0;
         hi_full_q   <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
         stuck_q     <= 1'b0;
         stuck_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         q_smp_q     <= q;
         j_smp_q     <= j;
         k_smp_q     <= k;
         en_smp_q    <= chk_en;
         rise_q      <= rise_d;
         fall_q      <= fall_d;
         vld_q       <= vld_d;
         tog_q       <= tog_d;
         hi_len_q    <= hi_len_d;
         hi_cnt_q    <= hi_cnt_d;
         hi_full_q   <= hi_full_d;
         err_q       <= err_d;
         err_cnt_q   <= err_cnt_d;
         stuck_q     <= stuck_d;
         stuck_cnt_q <= stuck_cnt_d;
      end
   end

   assign rise       = rise_q;
   assign fall       = fall_q;
   assign toggle_cnt = tog_q;
   assign hi_len     = hi_len_q;
   assign hi_len_vld = vld_q;
   assign err        = err_q;
   assign err_cnt    = err_cnt_q;
   assign stuck      = stuck_q;
   assign dbg_state  = state_q;

endmodule

// File: doc/jk_edge_monitor.md
JK_EDGE_MONITOR -- requirements
Module: jk_edge_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the toggle counter and the high-period length counter.
REQ-002 Parameter STUCK_LIM, default 16: number of consecutive cycles with j=k=1 and no q change that raises stuck.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserted when 0.
REQ-005 q  input  1  flip-flop output under observation, same clock domain.
REQ-006 j, k  input  1 each  flip-flop J and K inputs, sampled on the same edge the flip-flop samples them.
REQ-007 chk_en  input  1  enables next-state checking; 0 while the observed flip-flop is in its own reset.
REQ-008 clr  input  1  synchronous clear of counters and sticky flags.
REQ-009 rise, fall  output  1 each  single-cycle pulses on a q edge.
REQ-010 toggle_cnt  output  CNT_W  saturating count of q edges.
REQ-011 hi_len  output  CNT_W  length in cycles of the last completed high period; hi_len_vld  output  1  single-cycle pulse when hi_len updates.
REQ-012 err  output  1  sticky next-state mismatch flag; err_cnt  output  4  saturating mismatch count.
REQ-013 stuck  output  1  sticky flag for toggle commanded but not observed.

Function
REQ-014 Registered sample each cycle: q_r<=q, j_r<=j, k_r<=k, en_r<=chk_en.
REQ-015 FSM states UNKNOWN, LOW, HIGH; reset enters UNKNOWN.
REQ-016 UNKNOWN -> LOW if q=0, -> HIGH if q=1, on the first edge after reset release; no rise/fall in that transition.
REQ-017 LOW -> HIGH on q=1: rise=1 next cycle, high-length counter loads 1.
REQ-018 HIGH -> LOW on q=0: fall=1, hi_len<=high-length counter, hi_len_vld=1, all registered on that edge.
REQ-019 While in HIGH with q=1, the high-length counter increments and saturates at 2^CNT_W-1.
REQ-020 toggle_cnt increments on every rise or fall and saturates at 2^CNT_W-1 with no wrap.
REQ-021 Expected q = j_r&~k_r ? 1 : ~j_r&k_r ? 0 : j_r&k_r ? ~q_r : q_r.
REQ-022 When chk_en=1, en_r=1, state!=UNKNOWN and q!=expected: err<=1 and err_cnt increments, saturating at 15.
REQ-023 Stuck counter increments while j_r=k_r=1, chk_en=1 and q==q_r, and zeroes on any other cycle; on reaching STUCK_LIM, stuck<=1 (sticky).
REQ-024 clr=1: toggle_cnt, hi_len, err, err_cnt, stuck and the stuck counter go to 0 next edge; FSM state and q_r are kept.
REQ-025 clr coincident with an edge: the edge is still reported on rise/fall, and toggle_cnt ends at 0 (clear wins).
REQ-026 chk_en low for any cycle suppresses checking on that cycle and the next (en_r), so a flip-flop reset release does not flag.

Reset
REQ-027 rst=0 asynchronously forces state=UNKNOWN; rise, fall, hi_len_vld, err, stuck=0; toggle_cnt, hi_len, err_cnt, all internal counters and samples=0.
REQ-028 Reset mid-high-period discards the partial length; hi_len stays 0 until a full high period completes after release.
REQ-029 Outputs are held at reset values while rst=0 regardless of clk.

Verification
REQ-030 Reset release with q=0, then j=1,k=0 for 1 cycle -> one rise pulse 1 cycle after q rises; toggle_cnt=1; err=0.
REQ-031 j=k=1 for 6 cycles from q=0 -> 6 edges, rise/fall alternating; toggle_cnt=6; hi_len=1 with hi_len_vld at each fall.
REQ-032 q held at 1 for 5 cycles then j=0,k=1 -> hi_len=5 and hi_len_vld pulses once.
REQ-033 q forced opposite to the expected value for 1 cycle with chk_en=1 -> err=1, err_cnt=1; err stays 1 until clr.
REQ-034 j=k=1 with q held constant for 16 cycles -> stuck=1 on the 16th; at 15 cycles followed by a toggle, stuck stays 0.
REQ-035 CNT_W=4 with 20 toggles -> toggle_cnt saturates at 15; clr -> 0; rst pulse mid-high -> all outputs 0 and state UNKNOWN.
